// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix block multiplication datapath.
package matmul_pkg;

   localparam int unsigned DATA_W = 16;
   localparam int unsigned ACC_W  = 32;

   typedef enum logic [0:0] {ACCUM, HOLD} acc_state_t;

   typedef logic [1:0] elem_idx_t;

   localparam elem_idx_t C00 = 2'd0;
   localparam elem_idx_t C01 = 2'd1;
   localparam elem_idx_t C10 = 2'd2;
   localparam elem_idx_t C11 = 2'd3;

endpackage

// File: rtl/block_acc_lane.sv
// One signed accumulator lane: wrapping add with load-enable, clear and
// signed-overflow detection of the pending add.
module block_acc_lane #(
   parameter int unsigned ACC_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             clr,
   input  logic [ACC_W-1:0] addend,
   output logic [ACC_W-1:0] acc,
   output logic             ovf
);

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] sum;

   assign sum = acc_q + addend;

   // Overflow of the add as if enabled; the caller qualifies it with en.
   assign ovf = (acc_q[ACC_W-1] == addend[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

   always_ff @(posedge clock) begin
      if (!reset || clr) begin
         acc_q <= '0;
      end else if (en) begin
         acc_q <= sum;
      end
   end

   assign acc = acc_q;

endmodule

// File: rtl/block_accumulator.sv
// Sums serialized 2x2 partial product blocks into four lanes and presents the
// finished block through a valid/ready handshake.
module block_accumulator #(
   parameter int unsigned DATA_W = matmul_pkg::DATA_W,
   parameter int unsigned ACC_W  = matmul_pkg::ACC_W,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_c00,
   output logic [ACC_W-1:0]  out_c01,
   output logic [ACC_W-1:0]  out_c10,
   output logic [ACC_W-1:0]  out_c11,
   output logic [CNT_W-1:0]  out_count,
   output logic              out_ovf
);

   import matmul_pkg::*;

   acc_state_t       state_q, state_d;
   elem_idx_t        idx_q, idx_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;

   logic             accept;
   logic             lane_clr;
   logic [3:0]       lane_en;
   logic [3:0]       lane_ovf;
   logic [ACC_W-1:0] addend;
   logic [ACC_W-1:0] lane_acc [4];

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = (state_q == HOLD);
   assign accept    = in_valid && in_ready;
   assign lane_clr  = out_valid && out_ready;
   assign addend    = ACC_W'($signed(in_data));

   always_comb begin
      lane_en = '0;
      if (accept) begin
         lane_en[idx_q] = 1'b1;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : gen_lane
      block_acc_lane #(
         .ACC_W (ACC_W)
      ) u_lane (
         .clock  (clock),
         .reset  (reset),
         .en     (lane_en[i]),
         .clr    (lane_clr),
         .addend (addend),
         .acc    (lane_acc[i]),
         .ovf    (lane_ovf[i])
      );
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      unique case (state_q)
         ACCUM: begin
            if (accept) begin
               idx_d = idx_q + 2'd1;
               if (|(lane_ovf & lane_en)) begin
                  ovf_d = 1'b1;
               end
               if (idx_q == C11) begin
                  if (count_q != {CNT_W{1'b1}}) begin
                     count_d = count_q + 1'b1;
                  end
                  if (in_last) begin
                     state_d = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               idx_d   = C00;
               count_d = '0;
               ovf_d   = 1'b0;
               state_d = ACCUM;
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= ACCUM;
         idx_q   <= C00;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_c00   = lane_acc[0];
   assign out_c01   = lane_acc[1];
   assign out_c10   = lane_acc[2];
   assign out_c11   = lane_acc[3];
   assign out_count = count_q;
   assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_block_accumulator.sv
// Self-checking bench: directed scenarios plus randomized blocks against a
// plain-arithmetic reference model.
module tb_block_accumulator;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // DUT A: default widths (16-bit data, 32-bit lanes, 8-bit count)
   logic        a_ivalid = 1'b0, a_iready, a_ilast = 1'b0, a_ovalid, a_ordy = 1'b0, a_ovf;
   logic [15:0] a_data = '0;
   logic [31:0] a_c00, a_c01, a_c10, a_c11;
   logic [7:0]  a_count;

   block_accumulator u_dut_a (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (a_ivalid),
      .in_ready  (a_iready),
      .in_data   (a_data),
      .in_last   (a_ilast),
      .out_valid (a_ovalid),
      .out_ready (a_ordy),
      .out_c00   (a_c00),
      .out_c01   (a_c01),
      .out_c10   (a_c10),
      .out_c11   (a_c11),
      .out_count (a_count),
      .out_ovf   (a_ovf)
   );

   // DUT B: 16-bit lanes and a 2-bit counter for overflow and saturation
   logic        b_ivalid = 1'b0, b_iready, b_ilast = 1'b0, b_ovalid, b_ordy = 1'b0, b_ovf;
   logic [15:0] b_data = '0;
   logic [15:0] b_c00, b_c01, b_c10, b_c11;
   logic [1:0]  b_count;

   block_accumulator #(
      .DATA_W (16),
      .ACC_W  (16),
      .CNT_W  (2)
   ) u_dut_b (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (b_ivalid),
      .in_ready  (b_iready),
      .in_data   (b_data),
      .in_last   (b_ilast),
      .out_valid (b_ovalid),
      .out_ready (b_ordy),
      .out_c00   (b_c00),
      .out_c01   (b_c01),
      .out_c10   (b_c10),
      .out_c11   (b_c11),
      .out_count (b_count),
      .out_ovf   (b_ovf)
   );

   // Reference model for DUT A: exact integer sums, wrapped to 32 bits
   longint m_acc [4];
   int     m_pos;
   int     m_cnt;
   logic   m_ovf;

   function automatic void model_clear();
      for (int i = 0; i < 4; i++) m_acc[i] = 0;
      m_pos = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
   endfunction

   function automatic void model_beat(input logic [15:0] d);
      longint             s;
      logic signed [31:0] w;
      s = m_acc[m_pos] + longint'($signed(d));
      if (s > 64'sd2147483647 || s < -64'sd2147483648) m_ovf = 1'b1;
      w = s[31:0];
      m_acc[m_pos] = longint'(w);
      if (m_pos == 3 && m_cnt < 255) m_cnt = m_cnt + 1;
      m_pos = (m_pos + 1) % 4;
   endfunction

   function automatic logic [137:0] model_vec(input logic valid);
      logic [31:0] l0, l1, l2, l3;
      l0 = 32'(m_acc[0]);
      l1 = 32'(m_acc[1]);
      l2 = 32'(m_acc[2]);
      l3 = 32'(m_acc[3]);
      return {l0, l1, l2, l3, 8'(m_cnt), m_ovf, valid};
   endfunction

   logic [137:0] a_vec;
   assign a_vec = {a_c00, a_c01, a_c10, a_c11, a_count, a_ovf, a_ovalid};

   // Stimulus helpers (no checking inside)
   task automatic a_beat(input logic [15:0] d, input logic last);
      a_ivalid = 1'b1;
      a_data   = d;
      a_ilast  = last;
      model_beat(d);
      @(posedge clock);
      #1;
      a_ivalid = 1'b0;
      a_ilast  = 1'b0;
   endtask

   task automatic a_gap();
      a_ivalid = 1'b0;
      a_data   = 16'($urandom);
      a_ilast  = 1'($urandom);
      @(posedge clock);
      #1;
      a_ilast  = 1'b0;
   endtask

   task automatic a_take();
      a_ordy = 1'b1;
      @(posedge clock);
      #1;
      a_ordy = 1'b0;
      model_clear();
   endtask

   task automatic b_beat(input logic [15:0] d, input logic last);
      b_ivalid = 1'b1;
      b_data   = d;
      b_ilast  = last;
      @(posedge clock);
      #1;
      b_ivalid = 1'b0;
      b_ilast  = 1'b0;
   endtask

   task automatic b_take();
      b_ordy = 1'b1;
      @(posedge clock);
      #1;
      b_ordy = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      model_clear();
      n_tests++;
      if ({a_c00, a_c01, a_c10, a_c11, a_count, a_ovf, a_ovalid, a_iready} !== {138'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_a: got %h, wanted all-zero with in_ready=1", {a_vec, a_iready});
      end
      n_tests++;
      if ({b_c00, b_c01, b_c10, b_c11, b_count, b_ovf, b_ovalid, b_iready} !== {68'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_b: got %h %h %h %h cnt=%0d ovf=%b ov=%b ir=%b", b_c00, b_c01,
                  b_c10, b_c11, b_count, b_ovf, b_ovalid, b_iready);
      end
   endtask

   task automatic test_single_block();
      a_beat(16'd1, 1'b0);
      a_beat(16'd2, 1'b1);  // in_last off the c11 beat must be ignored
      a_beat(16'd3, 1'b0);
      n_tests++;
      if (a_ovalid !== 1'b0 || a_iready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_early: out_valid=%b in_ready=%b, wanted 0/1", a_ovalid, a_iready);
      end
      a_beat(16'd4, 1'b1);
      n_tests++;
      if (a_vec !== {32'd1, 32'd2, 32'd3, 32'd4, 8'd1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL single_block: got %h wanted lanes 1/2/3/4 count 1 ovf 0 valid 1", a_vec);
      end
      a_take();
      n_tests++;
      if (a_ovalid !== 1'b0 || a_iready !== 1'b1) begin
         n_fail++;
         $display("FAIL single_handshake: out_valid=%b in_ready=%b, wanted 0/1", a_ovalid, a_iready);
      end
   endtask

   task automatic test_back_to_back_and_backpressure();
      logic [137:0] want;
      for (int b = 0; b < 3; b++) begin
         a_beat(16'd10, 1'b0);
         a_beat(-16'sd5, 1'b0);
         a_beat(16'd7, 1'b0);
         a_beat(16'h7FFF, (b == 2));
      end
      want = {32'd30, 32'hFFFF_FFF1, 32'd21, 32'd98301, 8'd3, 1'b0, 1'b1};
      n_tests++;
      if (a_vec !== want) begin
         n_fail++;
         $display("FAIL three_blocks: got %h wanted %h", a_vec, want);
      end
      a_ivalid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         a_data = 16'($urandom);
         @(posedge clock);
         #1;
         n_tests++;
         if (a_iready !== 1'b0 || a_vec !== want) begin
            n_fail++;
            $display("FAIL backpressure[%0d]: in_ready=%b got %h wanted %h", c, a_iready, a_vec, want);
         end
      end
      a_take();
      a_ivalid = 1'b0;
      n_tests++;
      if ({a_vec, a_iready} !== {138'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL release_clear: got %h ir=%b wanted cleared with in_ready=1", a_vec, a_iready);
      end
      a_beat(16'd1, 1'b0);
      a_beat(16'd2, 1'b0);
      a_beat(16'd3, 1'b0);
      a_beat(16'd4, 1'b1);
      n_tests++;
      if (a_vec !== {32'd1, 32'd2, 32'd3, 32'd4, 8'd1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL after_release: got %h wanted lanes 1/2/3/4 count 1", a_vec);
      end
      a_take();
   endtask

   task automatic test_stalls();
      logic [137:0] want;
      want = {32'd3, 32'hFFFF_FFFC, 32'd5, 32'd6, 8'd1, 1'b0, 1'b1};
      for (int pass = 0; pass < 2; pass++) begin
         a_beat(16'd3, 1'b0);
         if (pass == 0) begin
            a_gap();
            a_gap();
            n_tests++;
            if ({a_c00, a_c01} !== {32'd3, 32'd0}) begin
               n_fail++;
               $display("FAIL stall_c00: got c00=%h c01=%h wanted 3/0", a_c00, a_c01);
            end
         end
         a_beat(-16'sd4, 1'b0);
         a_beat(16'd5, 1'b0);
         if (pass == 0) begin
            a_gap();
            a_gap();
            n_tests++;
            if ({a_c10, a_c11, a_ovalid} !== {32'd5, 32'd0, 1'b0}) begin
               n_fail++;
               $display("FAIL stall_c10: got c10=%h c11=%h ov=%b wanted 5/0/0", a_c10, a_c11, a_ovalid);
            end
         end
         a_beat(16'd6, 1'b1);
         n_tests++;
         if (a_vec !== want) begin
            n_fail++;
            $display("FAIL stalls[pass %0d]: got %h wanted %h", pass, a_vec, want);
         end
         a_take();
      end
   endtask

   task automatic test_reset_mid_block();
      a_beat(16'd9, 1'b0);
      a_beat(16'd9, 1'b0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      reset = 1'b1;
      model_clear();
      n_tests++;
      if ({a_vec, a_iready} !== {138'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_mid: got %h ir=%b wanted cleared", a_vec, a_iready);
      end
      a_beat(16'd5, 1'b0);
      a_beat(16'd6, 1'b0);
      a_beat(16'd7, 1'b0);
      a_beat(16'd8, 1'b1);
      n_tests++;
      if (a_vec !== {32'd5, 32'd6, 32'd7, 32'd8, 8'd1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_restart: got %h wanted lanes 5/6/7/8 count 1", a_vec);
      end
      a_take();
   endtask

   task automatic test_overflow_and_saturation();
      b_beat(16'h7FFF, 1'b0);
      b_beat(16'd0, 1'b0);
      b_beat(16'd0, 1'b0);
      b_beat(16'd0, 1'b0);
      b_beat(16'd1, 1'b0);
      b_beat(16'd0, 1'b0);
      b_beat(16'd0, 1'b0);
      b_beat(16'd0, 1'b1);
      n_tests++;
      if ({b_c00, b_c01, b_c10, b_c11, b_count, b_ovf, b_ovalid} !==
          {16'h8000, 16'd0, 16'd0, 16'd0, 2'd2, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL overflow: got %h %h %h %h cnt=%0d ovf=%b ov=%b, wanted 8000/0/0/0 2 1 1",
                  b_c00, b_c01, b_c10, b_c11, b_count, b_ovf, b_ovalid);
      end
      b_take();
      b_beat(16'd1, 1'b0);
      b_beat(16'd1, 1'b0);
      b_beat(16'd1, 1'b0);
      b_beat(16'd1, 1'b1);
      n_tests++;
      if ({b_c00, b_c01, b_c10, b_c11, b_count, b_ovf} !== {16'd1, 16'd1, 16'd1, 16'd1, 2'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL ovf_cleared: got %h %h %h %h cnt=%0d ovf=%b, wanted 1/1/1/1 1 0",
                  b_c00, b_c01, b_c10, b_c11, b_count, b_ovf);
      end
      b_take();
      for (int b = 0; b < 5; b++) begin
         b_beat(16'd1, 1'b0);
         b_beat(16'd2, 1'b0);
         b_beat(16'd3, 1'b0);
         b_beat(16'd4, (b == 4));
      end
      n_tests++;
      if ({b_c00, b_c01, b_c10, b_c11, b_count, b_ovf, b_ovalid} !==
          {16'd5, 16'd10, 16'd15, 16'd20, 2'd3, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL saturation: got %h %h %h %h cnt=%0d ovf=%b, wanted 5/10/15/20 3 0",
                  b_c00, b_c01, b_c10, b_c11, b_count, b_ovf);
      end
      b_take();
   endtask

   task automatic test_random();
      int          nblk;
      logic [15:0] d;
      for (int it = 0; it < 25; it++) begin
         nblk = $urandom_range(1, 4);
         for (int b = 0; b < nblk; b++) begin
            for (int e = 0; e < 4; e++) begin
               if ($urandom_range(0, 3) == 0) a_gap();
               // Large magnitudes make lane overflow likely over a few blocks
               d = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 31));
               a_beat(d, (e == 3) ? (b == nblk - 1) : 1'($urandom));
            end
         end
         n_tests++;
         if (a_vec !== model_vec(1'b1)) begin
            n_fail++;
            $display("FAIL random[%0d]: got %h wanted %h", it, a_vec, model_vec(1'b1));
         end
         repeat ($urandom_range(0, 2)) begin
            a_ivalid = 1'b1;
            a_data   = 16'($urandom);
            @(posedge clock);
            #1;
            a_ivalid = 1'b0;
            n_tests++;
            if (a_vec !== model_vec(1'b1) || a_iready !== 1'b0) begin
               n_fail++;
               $display("FAIL random_hold[%0d]: got %h ir=%b wanted %h ir=0", it, a_vec, a_iready,
                        model_vec(1'b1));
            end
         end
         a_take();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_clear();
      test_reset();
      test_single_block();
      test_back_to_back_and_backpressure();
      test_stalls();
      test_reset_mid_block();
      test_overflow_and_saturation();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
